// File: rtl/memory_stage_unit.sv
// -----------------------------------------------------------------------------
// memory_stage_unit
//
// Memory stage of the 16-bit pipelined CPU. It consumes the EX/MEM pipeline
// register and produces the MEM/WB register values. Pass ops (no load and no
// store) go straight to MEM/WB in one cycle. Loads and stores run a handshaked
// access on the data-memory port. The stage stalls upstream until the access
// completes or times out.
//
// Parameters
//   TIMEOUT_CYCLES  ACCESS cycles allowed without mem_ready before the access
//                   is aborted (1..255).
//
// Ports
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   valid_in        EX/MEM holds a real instruction (0 = bubble)
//   wbs_in          writeback enable
//   wme_in          store request (has priority over mm_in)
//   mm_in           load request
//   ALUresult_in    ALU result / word address for loads and stores
//   memData_in      store data
//   stall_out       hold upstream stages and the EX/MEM register (combinational)
//   mem_req/mem_we/mem_addr/mem_wdata   registered data-memory request
//   mem_rdata       read data, valid while mem_ready is high
//   mem_ready       memory completes the current request this cycle
//   wbs_out, result_out, valid_out, err_out   MEM/WB register outputs
// -----------------------------------------------------------------------------
module memory_stage_unit #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        wbs_in,
  input  logic        wme_in,
  input  logic        mm_in,
  input  logic [15:0] ALUresult_in,
  input  logic [15:0] memData_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        wbs_out,
  output logic [15:0] result_out,
  output logic        valid_out,
  output logic        err_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  // Last counter value before the access is abandoned.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic        lat_wbs;
  logic [15:0] rdata_q;
  logic        err_q;

  logic mem_op;
  logic pass_op;
  logic timeout_hit;

  assign mem_op      = valid_in & (wme_in | mm_in);
  assign pass_op     = valid_in & ~wme_in & ~mm_in;
  assign timeout_hit = ~mem_ready & (wait_cnt == LAST_CNT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and stall decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_next = state;
    stall_out  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall_out  = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        stall_out = 1'b1;
        if (mem_ready || timeout_hit) begin
          state_next = COMPLETE;
        end
      end
      COMPLETE: begin
        // Upstream advances on this edge; the held op is not re-issued.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latches, wait counter and MEM/WB register
  // ---------------------------------------------------------------------------
  // mem_addr / mem_we / mem_wdata double as the request latches: they are
  // loaded once on entry to ACCESS and stay stable for the whole access.
  // mem_addr also serves as the latched ALU result returned for stores.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: every latch is reset, not just the control bits, so outputs
      // are all-zero after reset and nothing stale leaks into MEM/WB.
      wait_cnt   <= 8'd0;
      lat_wbs    <= 1'b0;
      rdata_q    <= 16'd0;
      err_q      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 16'd0;
      mem_wdata  <= 16'd0;
      wbs_out    <= 1'b0;
      result_out <= 16'd0;
      valid_out  <= 1'b0;
      err_out    <= 1'b0;
    end else begin
      // Registered from the next state, so there is no combinational path
      // from mem_ready to the memory port.
      mem_req   <= (state_next == ACCESS);
      // valid_out and err_out are single-cycle pulses.
      valid_out <= 1'b0;
      err_out   <= 1'b0;

      case (state)
        IDLE: begin
          if (pass_op) begin
            valid_out  <= 1'b1;
            wbs_out    <= wbs_in;
            result_out <= ALUresult_in;
          end else if (mem_op) begin
            mem_addr  <= ALUresult_in;
            mem_wdata <= memData_in;
            mem_we    <= wme_in;
            lat_wbs   <= wbs_in;
            wait_cnt  <= 8'd0;
            err_q     <= 1'b0;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            if (!mem_we) begin
              rdata_q <= mem_rdata;
            end
            err_q <= 1'b0;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        COMPLETE: begin
          valid_out <= 1'b1;
          err_out   <= err_q;
          wbs_out   <= lat_wbs & ~err_q;
          if (mem_we) begin
            result_out <= mem_addr;
          end else if (err_q) begin
            result_out <= 16'hFFFF;
          end else begin
            result_out <= rdata_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage_unit.sv
// -----------------------------------------------------------------------------
// tb_memory_stage_unit
//
// Directed bench for memory_stage_unit with TIMEOUT_CYCLES = 4. Expected
// MEM/WB results are pushed to a scoreboard queue when an instruction is
// driven and popped by a monitor whenever valid_out is seen. Per-cycle checks
// cover stall, the memory request and the reset behaviour.
// -----------------------------------------------------------------------------
module tb_memory_stage_unit;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        wbs_in;
  logic        wme_in;
  logic        mm_in;
  logic [15:0] ALUresult_in;
  logic [15:0] memData_in;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        wbs_out;
  logic [15:0] result_out;
  logic        valid_out;
  logic        err_out;

  typedef struct {
    logic        wbs;
    logic [15:0] result;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int req_cycles = 0;
  int write_cnt  = 0;

  memory_stage_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .wbs_in       (wbs_in),
    .wme_in       (wme_in),
    .mm_in        (mm_in),
    .ALUresult_in (ALUresult_in),
    .memData_in   (memData_in),
    .stall_out    (stall_out),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .wbs_out      (wbs_out),
    .result_out   (result_out),
    .valid_out    (valid_out),
    .err_out      (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wbs, input logic wme, input logic mm,
                       input logic [15:0] alu, input logic [15:0] data);
    valid_in     = v;
    wbs_in       = wbs;
    wme_in       = wme;
    mm_in        = mm;
    ALUresult_in = alu;
    memData_in   = data;
    #1;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic push_exp(input logic wbs, input logic [15:0] res, input logic err);
    exp_t e;
    e.wbs    = wbs;
    e.result = res;
    e.err    = err;
    exp_q.push_back(e);
  endtask

  // Monitor: scoreboard compare on every completed instruction, plus counters
  // of request cycles and accepted writes.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_req === 1'b1) begin
        req_cycles++;
        if (mem_ready === 1'b1 && mem_we === 1'b1) write_cnt++;
      end
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(valid_out), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_result", 64'(result_out), 64'(e.result));
          check("sb_wbs",    64'(wbs_out),    64'(e.wbs));
          check("sb_err",    64'(err_out),    64'(e.err));
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    bubble();
    step();
    step();
    rst_n = 1'b1;
    #1;

    // ---- reset state ----
    check("rst_outputs",
          64'({mem_req, mem_we, mem_addr, mem_wdata, wbs_out, result_out, valid_out, err_out}),
          64'd0);
    check("rst_stall", 64'(stall_out), 64'd0);

    // ---- pass op ----
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
    check("pass_stall_c0", 64'(stall_out), 64'd0);
    push_exp(1'b1, 16'h1234, 1'b0);
    step();
    bubble();
    check("pass_valid_c1", 64'({valid_out, wbs_out, result_out}), 64'({1'b1, 1'b1, 16'h1234}));
    check("pass_no_req", 64'(mem_req), 64'd0);
    step();
    check("pass_pulse", 64'(valid_out), 64'd0);

    // ---- store with 2 wait cycles ----
    req_cycles = 0;
    write_cnt  = 0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'hBEEF);
    check("st_stall_c0", 64'(stall_out), 64'd1);
    push_exp(1'b0, 16'h0040, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      step();
      mem_ready = (c == 3);
      #1;
      check("st_req", 64'({mem_req, mem_we, mem_addr, mem_wdata}),
            64'({1'b1, 1'b1, 16'h0040, 16'hBEEF}));
      check("st_stall", 64'(stall_out), 64'd1);
    end
    step();
    mem_ready = 1'b0;
    check("st_complete", 64'({mem_req, stall_out, valid_out}), 64'd0);
    bubble();
    step();
    check("st_valid_c5", 64'(valid_out), 64'd1);
    check("st_req_cycles", 64'(req_cycles), 64'd3);
    check("st_writes", 64'(write_cnt), 64'd1);

    // ---- load, ready on first ACCESS cycle, then pass op ----
    req_cycles = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
    check("ld_stall_c0", 64'(stall_out), 64'd1);
    push_exp(1'b1, 16'hA5A5, 1'b0);
    step();
    check("ld_req_c1", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b0, 16'h0010}));
    mem_ready = 1'b1;
    mem_rdata = 16'hA5A5;
    step();
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    #1;
    // EX/MEM still holds the load in COMPLETE; it must be ignored.
    check("ld_complete_stall", 64'({stall_out, mem_req}), 64'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0007, 16'h0000);
    push_exp(1'b1, 16'h0007, 1'b0);
    check("ld_valid_c3", 64'({valid_out, result_out}), 64'({1'b1, 16'hA5A5}));
    check("ld_pass_stall_c3", 64'(stall_out), 64'd0);
    step();
    bubble();
    check("ld_pass_c4", 64'({valid_out, result_out}), 64'({1'b1, 16'h0007}));
    step();
    check("ld_no_reissue", 64'({mem_req, 8'(req_cycles)}), 64'({1'b0, 8'd1}));

    // ---- wme and mm together: store wins ----
    req_cycles = 0;
    write_cnt  = 0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 16'h5555);
    push_exp(1'b0, 16'h0002, 1'b0);
    step();
    check("both_req", 64'({mem_req, mem_we, mem_addr, mem_wdata}),
          64'({1'b1, 1'b1, 16'h0002, 16'h5555}));
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    bubble();
    step();
    check("both_valid", 64'(valid_out), 64'd1);
    check("both_single_write", 64'({8'(write_cnt), 8'(req_cycles)}), 64'({8'd1, 8'd1}));

    // ---- load timeout ----
    req_cycles = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0080, 16'h0000);
    push_exp(1'b0, 16'hFFFF, 1'b1);
    for (int c = 1; c <= TIMEOUT; c++) begin
      step();
      check("to_req", 64'({mem_req, stall_out}), 64'({1'b1, 1'b1}));
    end
    step();
    check("to_complete", 64'({mem_req, stall_out}), 64'd0);
    bubble();
    step();
    check("to_valid_c6", 64'({valid_out, err_out, wbs_out, result_out}),
          64'({1'b1, 1'b1, 1'b0, 16'hFFFF}));
    check("to_req_cycles", 64'(req_cycles), 64'(TIMEOUT));
    step();
    check("to_pulse", 64'({valid_out, err_out}), 64'd0);

    // ---- reset during the second ACCESS cycle ----
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000);
    step();
    step();
    check("rstmid_req_c2", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    bubble();
    step();
    check("rstmid_outputs",
          64'({mem_req, mem_we, mem_addr, mem_wdata, wbs_out, result_out, valid_out, err_out}),
          64'd0);
    check("rstmid_stall", 64'(stall_out), 64'd0);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h00AA, 16'h0000);
    push_exp(1'b1, 16'h00AA, 1'b0);
    step();
    bubble();
    check("rstmid_pass", 64'({valid_out, result_out}), 64'({1'b1, 16'h00AA}));
    step();
    step();

    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
